// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Also holds the request legality helpers used by dmem_lsu.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned sizes only make sense for loads.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (f3[2] && we);
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] off);
        return (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) || ((f3 == F3_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Lane extraction with sign/zero extension for loads, and byte/halfword
// merge into a previously read word for sub-word stores.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword lane follows addr[1] only; addr[0] is ignored by design.
    always_comb begin
        byte_sel = word_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];

        case (funct3_i)
            F3_B:    load_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_o = {24'd0, byte_sel};
            F3_H:    load_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_o = {16'd0, half_sel};
            default: load_o = word_i;
        endcase

        merge_o = word_i;
        case (funct3_i)
            F3_B: merge_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
            F3_H: begin
                if (off_i[1]) merge_o[31:16] = wdata_i[15:0];
                else          merge_o[15:0]  = wdata_i[15:0];
            end
            default: merge_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit between a core request port and a single-cycle data memory.
// Define DMEM_LSU_MISALIGN_TRAP_EN to report misaligned h/hu/w as errors.
module dmem_lsu
    import dmem_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    output logic        mem_WE,
    input  logic [31:0] mem_RD
);

    state_e      state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdword_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        bad_req_d;
    logic [31:0] align_word_d;
    logic [31:0] load_data;
    logic [31:0] merge_data;

    always_comb begin
        bad_req_d = f3_illegal(req_funct3, req_we);
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
        bad_req_d = bad_req_d || f3_misaligned(req_funct3, req_addr[1:0]);
`else
        bad_req_d = bad_req_d;
`endif
    end

    // Live memory data during READ, captured word afterwards for the store merge.
    assign align_word_d = (state_q == READ) ? mem_RD : rdword_q;

    dmem_lsu_align u_align (
        .funct3_i (f3_q),
        .off_i    (addr_q[1:0]),
        .word_i   (align_word_d),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            f3_q        <= 3'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdword_q    <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (bad_req_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            state_q <= WRITE;
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                READ: begin
                    rdword_q <= mem_RD;
                    if (we_q) begin
                        state_q <= WRITE;
                    end else begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= load_data;
                    end
                end
                WRITE: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= 32'd0;
                end
            endcase
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

    // Reset in the WRITE cycle must not reach the memory.
    assign mem_A  = ((state_q == READ) || (state_q == WRITE)) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_WD = (state_q == WRITE) ? merge_data : 32'd0;
    assign mem_WE = (state_q == WRITE) && !rst;

endmodule
